// File: rtl/q_instr_sched.sv
// Timed dispatch scheduler: buffers combined instruction words in a FIFO and
// releases each one when the free-running 20-bit timeline reaches its time field.
module q_instr_sched #(
  parameter  int NCH   = 110,
  parameter  int DEPTH = 16,
  localparam int W     = 52 + 4*NCH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          stop,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [19:0]   now,
  output logic [AW:0]   fill,
  output logic          running,
  output logic          late_err,
  output logic [15:0]   late_cnt
);

  localparam logic [0:0]  IDLE     = 1'b0;
  localparam logic [0:0]  RUN      = 1'b1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [0:0]    state;
  logic [19:0]   now_q;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic [W-1:0]  head;
  logic [19:0]   diff;
  logic          empty;
  logic          push;
  logic          due;
  logic          slot_free;
  logic          pop;
  logic          late;

  assign head      = mem[rd_ptr];
  assign empty     = (count == '0);
  assign in_ready  = (count != FULL_CNT);
  assign push      = in_valid && in_ready;
  // Modular difference: bit 19 set means the head time is already behind now.
  assign diff      = head[W-1 -: 20] - now_q;
  assign due       = (state == RUN) && !empty && ((diff == '0) || diff[19]);
  assign slot_free = !out_valid || out_ready;
  assign pop       = due && slot_free;
  assign late      = pop && (diff != '0);

  assign now     = now_q;
  assign fill    = count;
  assign running = (state == RUN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      now_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          now_q <= '0;
          if (start && !stop) state <= RUN;
        end
        default: begin
          if (stop) begin
            state <= IDLE;
            now_q <= '0;
          end else begin
            now_q <= now_q + 20'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      late_err  <= 1'b0;
      late_cnt  <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      late_err  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (pop) begin
        out_data  <= head;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      late_err <= late;
      if (late && (late_cnt != 16'hFFFF)) late_cnt <= late_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_q_instr_sched.sv
// Scoreboard bench for q_instr_sched: directed pushes queue their expected
// issue (word, now at issue, late flag); a monitor checks each new output word.
module tb_q_instr_sched;

  localparam int NCH   = 110;
  localparam int DEPTH = 16;
  localparam int W     = 52 + 4*NCH;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          stop;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [19:0]   now;
  logic [AW:0]   fill;
  logic          running;
  logic          late_err;
  logic [15:0]   late_cnt;

  q_instr_sched #(.NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .now(now), .fill(fill), .running(running),
    .late_err(late_err), .late_cnt(late_cnt)
  );

  typedef struct {
    logic [W-1:0] data;
    int           t;     // expected now while the word is first presented, -1 = not checked
    bit           late;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] mk(logic [19:0] t, logic [15:0] tag);
    logic [W-1:0] d;
    d = '0;
    d[W-1 -: 20] = t;
    d[15:0] = tag;
    return d;
  endfunction

  function automatic void expect_issue(logic [19:0] t, logic [15:0] tag, int at_now, bit late);
    exp_t e;
    e.data = mk(t, tag);
    e.t    = at_now;
    e.late = late;
    q.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [19:0] t, input logic [15:0] tag);
    in_valid = 1'b1;
    in_data  = mk(t, tag);
    tick();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_now(input logic [19:0] v);
    int n;
    n = 0;
    while (now !== v && n < 300) begin
      tick();
      n++;
    end
    chk("wait_now", now, v);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_in_ready"},  in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"},  32'(out_data != '0), 0);
    chk({tag, "_now"},       now, 0);
    chk({tag, "_fill"},      fill, 0);
    chk({tag, "_running"},   running, 0);
    chk({tag, "_late_err"},  late_err, 0);
    chk({tag, "_late_cnt"},  late_cnt, 0);
  endtask

  // Monitor: a word is new when out_valid is high and the previous cycle
  // either had no word or completed a handshake.
  initial begin
    bit   prev_v;
    bit   prev_r;
    exp_t e;
    prev_v = 1'b0;
    prev_r = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_v = 1'b0;
        prev_r = 1'b0;
      end else begin
        if (out_valid === 1'b1 && (!prev_v || prev_r)) begin
          n_checks++;
          if (q.size() == 0) begin
            $display("FAIL unexpected_issue: got time=%h tag=%h now=%h, required no issue",
                     out_data[W-1 -: 20], out_data[15:0], now);
          end else begin
            e = q.pop_front();
            if (out_data === e.data && late_err === e.late &&
                (e.t < 0 || now === 20'(e.t)))
              n_pass++;
            else
              $display("FAIL issue: got time=%h tag=%h late=%b now=%h, required time=%h tag=%h late=%b now=%0d",
                       out_data[W-1 -: 20], out_data[15:0], late_err, now,
                       e.data[W-1 -: 20], e.data[15:0], e.late, e.t);
          end
        end else begin
          n_checks++;
          if (late_err === 1'b0) n_pass++;
          else $display("FAIL spurious_late_err: got %b, required 0 (now=%h)", late_err, now);
        end
        prev_v = out_valid;
        prev_r = out_ready;
      end
    end
  end

  initial begin
    logic [19:0] nb;
    reset_n   = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #3;
    chk_reset_values("reset");
    #9 reset_n = 1'b1;
    tick();

    // Basic timed issue: 5, 9, 9 (second 9 late by one)
    out_ready = 1'b1;
    expect_issue(20'd5, 16'd1, 6, 1'b0);
    expect_issue(20'd9, 16'd2, 10, 1'b0);
    expect_issue(20'd9, 16'd3, 11, 1'b1);
    push(20'd5, 16'd1);
    push(20'd9, 16'd2);
    push(20'd9, 16'd3);
    chk("fill_3", fill, 3);
    pulse_start();
    chk("run_now0", now, 0);
    chk("run_running", running, 1);
    repeat (13) tick();
    chk("basic_late_cnt", late_cnt, 1);
    chk("basic_fill", fill, 0);

    // Late on entry
    wait_now(20'd100);
    expect_issue(20'd40, 16'd4, 102, 1'b1);
    push(20'd40, 16'd4);
    repeat (4) tick();
    chk("late_entry_cnt", late_cnt, 2);

    // start in RUN ignored; start with stop -> stop wins
    nb = now;
    pulse_start();
    chk("start_in_run_running", running, 1);
    chk("start_in_run_now", now, nb + 20'd1);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("stop_wins_running", running, 0);
    chk("stop_now", now, 0);
    tick();
    chk("idle_now_held", now, 0);

    // Wrap-around: timeline forced to 0xFFFFE at the start edge
    expect_issue(20'hFFFFF, 16'd5, 0, 1'b0);
    expect_issue(20'h00001, 16'd6, 2, 1'b0);
    push(20'hFFFFF, 16'd5);
    push(20'h00001, 16'd6);
    force dut.now_q = 20'hFFFFE;
    start = 1'b1;
    tick();
    release dut.now_q;
    start = 1'b0;
    chk("wrap_forced_now", now, 20'hFFFFE);
    repeat (5) tick();
    chk("wrap_late_cnt", late_cnt, 2);
    chk("wrap_fill", fill, 0);

    // Backpressure and full
    stop = 1'b1;
    tick();
    stop = 1'b0;
    out_ready = 1'b0;
    expect_issue(20'd0, 16'd16, 1, 1'b0);
    for (int i = 1; i < DEPTH; i++) expect_issue(20'd0, 16'(16 + i), -1, 1'b1);
    for (int i = 0; i < DEPTH; i++) push(20'd0, 16'(16 + i));
    chk("full_fill", fill, 16);
    chk("full_in_ready", in_ready, 0);
    push(20'd0, 16'd99);
    chk("full_push_dropped", fill, 16);
    pulse_start();
    tick();
    chk("bp_held_valid", out_valid, 1);
    chk("bp_fill_15", fill, 15);
    for (int i = 0; i < DEPTH - 1; i++) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_drained_valid", out_valid, 0);
    chk("bp_drained_fill", fill, 0);
    chk("bp_late_cnt", late_cnt, 17);

    // flush with push, fill=3 and a word held in out
    expect_issue(20'd0, 16'd30, -1, 1'b1);
    push(20'd0, 16'd30);
    push(20'd0, 16'd31);
    push(20'd0, 16'd32);
    push(20'd0, 16'd33);
    chk("preflush_fill", fill, 3);
    chk("preflush_valid", out_valid, 1);
    nb = now;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = mk(20'd0, 16'd34);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    chk("flush_fill", fill, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_now_runs", now, nb + 20'd1);
    chk("flush_late_cnt", late_cnt, 18);
    repeat (2) tick();
    chk("flush_fill_after", fill, 0);
    chk("flush_valid_after", out_valid, 0);

    // Async reset mid-run
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int i = 0; i < 4; i++) push(20'd1000, 16'(40 + i));
    pulse_start();
    wait_now(20'd50);
    chk("prereset_fill", fill, 4);
    #2 reset_n = 1'b0;
    #1;
    chk_reset_values("async_reset");
    #3 reset_n = 1'b1;
    tick();
    chk("post_reset_now", now, 0);
    chk("post_reset_running", running, 0);
    pulse_start();
    chk("restart_now0", now, 0);
    chk("restart_running", running, 1);
    chk("restart_fill", fill, 0);
    tick();
    chk("restart_now1", now, 1);

    repeat (3) tick();
    chk("scoreboard_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/q_instr_sched.md
# q_instr_sched

Timed dispatch scheduler for combined quantum instruction words. It buffers words produced by the instruction combiner in a FIFO and keeps a free-running 20-bit timeline counter. It releases each word to the downstream channel drivers in the cycle after the timeline reaches the word's absolute time field. It sits between the instruction-combine stage and the pulse/channel back end. It is the single point that sequences combined instructions onto the hardware timeline.

## Interface
- NCH, 110, number of qubit channels; word width W = 52+4*NCH (time[19:0] in bits W-1:W-20)
- DEPTH, 16, FIFO entries (power of two, ≥2)
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  pulse: start timeline (IDLE→RUN)
- stop  in  1  pulse: stop timeline (RUN→IDLE)
- flush  in  1  pulse: discard FIFO and output register
- in_valid  in  1  input word valid
- in_ready  out  1  FIFO can accept (count != DEPTH)
- in_data  in  W  combined instruction word
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts
- out_data  out  W  issued word (unchanged from input)
- now  out  20  current timeline value
- fill  out  $clog2(DEPTH)+1  FIFO occupancy
- running  out  1  state == RUN
- late_err  out  1  one-cycle pulse: word issued with time != now
- late_cnt  out  16  saturating count of late issues

## Operation
- States: IDLE (now held at 0, no issue), RUN (now increments by 1 per cycle, 2^20-1 wraps to 0).
- IDLE + start → RUN. now=0 in the first RUN cycle.
- RUN + stop → IDLE. now cleared to 0. FIFO contents and out register kept.
- start in RUN and stop in IDLE are ignored. start and stop together: stop wins.
- Push: in_valid && in_ready writes in_data at the tail. No bypass: in_ready depends only on count.
- Head time H = head[W-1:W-20]; diff = (H − now) mod 2^20.
- due = RUN && !empty && (diff == 0 || diff[19] == 1). diff[19] marks the head as late, wrap-safe.
- slot_free = !out_valid || out_ready.
- Pop when due && slot_free:
  - out_data ← head; out_valid ← 1.
  - If diff != 0: late_err pulses the same cycle out_valid rises, and late_cnt increments (saturates at 0xFFFF).
- out_valid clears on out_ready with no concurrent pop.
- Words issue strictly in FIFO order. A future-timed head blocks younger words.
- flush takes precedence over push, pop and the late update in its cycle:
  - count → 0, pointers reset, out_valid → 0.
  - late_cnt, state and now are unaffected.
- Simultaneous push and pop: both occur, count unchanged.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, now=0, fill=0, running=0, late_err=0, late_cnt=0; state IDLE.
- Reset mid-operation clears everything asynchronously. Nothing is retained.
- Issue latency:
  - A word with H=T, already resident and with a free slot, gives out_valid=1 in the cycle after now==T.
  - out_data is stable until accepted.
- Push-to-issue minimum: 2 cycles (write cycle, then head evaluation).
- Backpressure: if out_ready stays low past now==T, the word issues late on the first free cycle, with late_err.
- Throughput: one word per cycle when consecutive heads are due and out_ready=1.
- Full: in_ready=0 when fill==DEPTH. A push attempted while full is not written.

## Test plan
- Basic timed issue:
  - Push words with time 5, 9, 9. Pulse start. Hold out_ready=1.
  - Required: out_valid high in the cycles after now=5 and now=9, then again after now=10 (the second 9 is late, late_err=1, late_cnt=1).
- Late on entry:
  - start, wait until now=100, push time 40.
  - Required: issue 2 cycles later, late_err pulse, late_cnt=1.
- Wrap-around:
  - Force the timeline to now=0xFFFFE. Resident heads with times 0xFFFFF and 0x00001.
  - Required: issues after now=0xFFFFF and after now=0x00001, no late_err.
- Backpressure and full:
  - Fill DEPTH=16 words, all time 0. Hold out_ready=0 from start.
  - Required: in_ready=0 at fill=16. One word held in out. The remaining 15 issue in order as out_ready pulses, each flagged late.
- flush with push:
  - Assert flush and in_valid together, with fill=3 and out_valid=1.
  - Required: next cycle fill=0, out_valid=0, pushed word discarded, now continuing.
- Async reset mid-run:
  - Drop reset_n at now=50 with fill=4.
  - Required: all outputs at reset values immediately. start again gives now=0.
